neuron_feeder: RTL and testbench
================================

# neuron_feeder

Transmit-side sequencer for the 4-lane neuron MAC. It accepts an activation vector one element per beat over a valid/ready stream and buffers the whole vector. It then issues the vector to the neuron as back-to-back 4-lane beats, with one `input_ready` pulse per beat and weights fetched from a synchronous weight memory. It sits between the previous layer's output stream and one neuron instance, and drives that neuron's `input_ready`, `in0..in3` and `w0..w3`.

## Interface
- `IN_W`, default 5: activation width; must match the neuron's `input_width`.
- `NUM_IN`, default 16: activations per vector; any value ≥ 1.
- `NUM_GRP`, derived, ceil(`NUM_IN`/4): beats per vector.
- `GA_W`, derived, max(1, $clog2(`NUM_GRP`)): weight address width.
- `gated_clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `act_valid`  in  1  upstream activation valid.
- `act_ready`  out  1  feeder can accept an activation.
- `act_data`  in  `IN_W`  signed activation.
- `wt_addr`  out  `GA_W`  weight group address.
- `wt_data`  in  20  packed weights `{w3,w2,w1,w0}`, each 5-bit signed; valid one cycle after `wt_addr`.
- `in0..in3`  out  `IN_W` each  lane activations to the neuron.
- `w0..w3`  out  5 each  lane weights to the neuron.
- `input_ready`  out  1  beat valid to the neuron.
- `group_last`  out  1  high with the final beat of a vector.

## Operation
- States: LOAD, PRIME, STREAM. Reset state is LOAD.
- **LOAD**
  - `act_ready`=1.
  - A transfer happens when `act_valid`&&`act_ready`: `act_data` is written to buffer slot `fill_cnt`, and `fill_cnt` increments.
  - When the transfer is at `fill_cnt`==`NUM_IN`-1: `fill_cnt`←0 and go to PRIME.
- **PRIME**
  - `act_ready`=0, `wt_addr`=0, `grp`←0.
  - Go to STREAM on the next cycle.
- **STREAM**, for group `grp`:
  - `act_ready`=0.
  - Output registers load `inK`←buffer[4·`grp`+K], or 0 when 4·`grp`+K ≥ `NUM_IN` (zero padding).
  - `wK`←`wt_data`[5K+4:5K]. Weights are not masked; zero padding in the activation lane alone nulls the product.
  - `input_ready`←1. `group_last`←(`grp`==`NUM_GRP`-1).
  - `wt_addr`=`grp`+1 while `grp`<`NUM_GRP`-1; otherwise 0.
  - `grp` increments. After the last group, go to LOAD.
- In any cycle where a beat is not loaded, `input_ready` and `group_last` register to 0. `in`/`w` outputs hold their last values.
- `act_valid` outside LOAD is ignored, and data is not consumed. Upstream must hold it.
- The buffer is not cleared between vectors. Every slot is rewritten before it is read.

## Timing
- Reset values: `act_ready`=1 (LOAD), `wt_addr`=0, `in0..in3`=0, `w0..w3`=0, `input_ready`=0, `group_last`=0, `fill_cnt`=0, `grp`=0.
- Reset asserted mid-operation (LOAD, PRIME or STREAM) aborts the vector. Any partially loaded or partially issued data is discarded. There is no pulse on deassert.
- If the last activation is accepted in cycle t:
  - PRIME occupies t+1.
  - STREAM occupies t+2 .. t+1+`NUM_GRP`.
  - `input_ready` is high in t+3 .. t+2+`NUM_GRP`, contiguous.
  - `group_last` is high in t+2+`NUM_GRP`.
- `act_ready` returns high in cycle t+2+`NUM_GRP`, the cycle the last beat is visible. A new vector may be loaded while the neuron consumes the final beat.
- Minimum vector period: `NUM_IN`+`NUM_GRP`+1 cycles.
- `act_ready` and `wt_addr` are combinational from state and counters. All neuron-facing outputs are registered.
- `NUM_GRP`=1 case: PRIME → one STREAM cycle → LOAD. The single beat has `group_last`=1.

## Structure
- Package `neuron_pkg`:
  - `LANES`=4 and `WT_W`=5.
  - `typedef enum logic [1:0] {LOAD, PRIME, STREAM} feed_state_t`.
  - Function `ceil_div(a,b)`.
- Sub-module `act_buffer`:
  - `NUM_IN`×`IN_W` register file with write port (`we`, `waddr`, `wdata`) and a 4-lane combinational read by group index, with zero padding for out-of-range slots.
  - Its registers reset to 0.
- Top level holds the FSM, `fill_cnt`, `grp` and the output registers.

## Test plan
- `NUM_IN`=8, acts 1..8, `act_valid` held high, weight memory G0={1,1,1,1}, G1={2,2,2,2}:
  - Required: 8 consecutive transfers, then exactly 2 `input_ready` cycles.
  - Beat 0: in=1,2,3,4, w=1.
  - Beat 1: in=5,6,7,8, w=2, `group_last`=1.
  - Neuron sums are 10 and 52.
- `NUM_IN`=6, acts −16,15,−1,7,3,−2, all weights −16:
  - Beat 1 in=3,−2,0,0 (padded). `group_last` only on beat 1.
- Toggle `act_valid` 1,0,1,0… during LOAD:
  - Only the valid cycles fill the buffer. Beats start 2 cycles after the 8th transfer.
  - `act_valid` held high during STREAM causes no transfers.
- Back-to-back vectors: first beat of vector B lands exactly `NUM_IN`+`NUM_GRP`+1 cycles after first beat of vector A. No beat is dropped or duplicated.
- Assert `rst_n`=0 during STREAM beat 0:
  - Outputs go to 0 asynchronously and `act_ready`=1 after release.
  - The next vector streams correctly with no stale beat.
- `NUM_IN`=1, act=−5, w={3,x,x,x}: one beat in0=−5, in1..3=0, `input_ready`=`group_last`=1 for exactly one cycle.

Source files
------------

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module : neuron_pkg
// Brief  : Shared lane/weight constants, feeder state type and sizing helper.
// Rev    : 1.0
// ============================================================================
package neuron_pkg;

    localparam int LANES = 4;
    localparam int WT_W  = 5;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } feed_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_feeder_act_buffer.sv
`default_nettype none
// ============================================================================
// Module : act_buffer
// Brief  : Activation register file, one write port, 4-lane zero-padded read.
// Rev    : 1.0
// ============================================================================
module act_buffer
    import neuron_pkg::*;
#(
    parameter int IN_W   = 5,
    parameter int NUM_IN = 16,
    parameter int AW     = 4,
    parameter int GA_W   = 2
) (
    input  logic                    gated_clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [IN_W-1:0]         wdata,
    input  logic [GA_W-1:0]         rgrp,
    output logic [LANES*IN_W-1:0]   rdata
);

    localparam int DEPTH = 1 << AW;
    localparam int PAD   = (1 << GA_W) * LANES;

    logic [IN_W-1:0] mem    [DEPTH];
    logic [IN_W-1:0] padded [PAD];

    always_ff @(posedge gated_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Slots past the vector end read as zero so padded lanes null their product.
    for (genvar i = 0; i < PAD; i++) begin : g_pad
        if (i < NUM_IN) begin : g_live
            assign padded[i] = mem[i];
        end else begin : g_zero
            assign padded[i] = '0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [1:0] LANE = 2'(k);
        assign rdata[k*IN_W +: IN_W] = padded[{rgrp, LANE}];
    end

endmodule
`default_nettype wire

// File: rtl/neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module : neuron_feeder
// Brief  : Buffers one activation vector, then issues it as 4-lane beats.
// Rev    : 1.0
// ============================================================================
module neuron_feeder
    import neuron_pkg::*;
#(
    parameter  int IN_W    = 5,
    parameter  int NUM_IN  = 16,
    localparam int NUM_GRP = ceil_div(NUM_IN, LANES),
    localparam int GA_W    = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
    input  logic                     gated_clk,
    input  logic                     rst_n,
    input  logic                     act_valid,
    output logic                     act_ready,
    input  logic signed [IN_W-1:0]   act_data,
    output logic [GA_W-1:0]          wt_addr,
    input  logic [LANES*WT_W-1:0]    wt_data,
    output logic signed [IN_W-1:0]   in0,
    output logic signed [IN_W-1:0]   in1,
    output logic signed [IN_W-1:0]   in2,
    output logic signed [IN_W-1:0]   in3,
    output logic signed [WT_W-1:0]   w0,
    output logic signed [WT_W-1:0]   w1,
    output logic signed [WT_W-1:0]   w2,
    output logic signed [WT_W-1:0]   w3,
    output logic                     input_ready,
    output logic                     group_last
);

    localparam int              FC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [FC_W-1:0] FILL_LAST = FC_W'(NUM_IN - 1);
    localparam logic [GA_W-1:0] GRP_LAST  = GA_W'(NUM_GRP - 1);

    feed_state_t                state;
    logic [FC_W-1:0]            fill_cnt;
    logic [GA_W-1:0]            grp;
    logic [LANES*IN_W-1:0]      lanes;
    logic                       take;

    assign act_ready = (state == LOAD);
    assign take      = act_valid && act_ready;

    // Address runs one group ahead so the synchronous weight read lines up with grp.
    always_comb begin
        wt_addr = '0;
        if (state == STREAM && grp != GRP_LAST) begin
            wt_addr = grp + GA_W'(1);
        end
    end

    act_buffer #(
        .IN_W   (IN_W),
        .NUM_IN (NUM_IN),
        .AW     (FC_W),
        .GA_W   (GA_W)
    ) u_buf (
        .gated_clk (gated_clk),
        .rst_n     (rst_n),
        .we        (take),
        .waddr     (fill_cnt),
        .wdata     (act_data),
        .rgrp      (grp),
        .rdata     (lanes)
    );

    always_ff @(posedge gated_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            fill_cnt    <= '0;
            grp         <= '0;
            in0         <= '0;
            in1         <= '0;
            in2         <= '0;
            in3         <= '0;
            w0          <= '0;
            w1          <= '0;
            w2          <= '0;
            w3          <= '0;
            input_ready <= 1'b0;
            group_last  <= 1'b0;
        end else begin
            input_ready <= 1'b0;
            group_last  <= 1'b0;
            case (state)
                LOAD: begin
                    if (take) begin
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt <= '0;
                            state    <= PRIME;
                        end else begin
                            fill_cnt <= fill_cnt + FC_W'(1);
                        end
                    end
                end
                PRIME: begin
                    grp   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    in0         <= lanes[0*IN_W +: IN_W];
                    in1         <= lanes[1*IN_W +: IN_W];
                    in2         <= lanes[2*IN_W +: IN_W];
                    in3         <= lanes[3*IN_W +: IN_W];
                    w0          <= wt_data[0*WT_W +: WT_W];
                    w1          <= wt_data[1*WT_W +: WT_W];
                    w2          <= wt_data[2*WT_W +: WT_W];
                    w3          <= wt_data[3*WT_W +: WT_W];
                    input_ready <= 1'b1;
                    group_last  <= (grp == GRP_LAST);
                    if (grp == GRP_LAST) begin
                        grp   <= '0;
                        state <= LOAD;
                    end else begin
                        grp <= grp + GA_W'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_neuron_feeder
// Brief  : Self-checking bench: behavioural beat model plus directed vectors.
// Rev    : 1.0
// ============================================================================
module tb_neuron_feeder;
    import neuron_pkg::*;

    localparam int NA  = 8;
    localparam int NGA = 2;

    typedef struct packed {
        int          cyc;
        logic [19:0] ins;
        logic [19:0] ws;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // DUT A: NUM_IN=8
    logic              va = 1'b0;
    logic [4:0]        da = '0;
    logic              ra, ir_a, gl_a;
    logic [0:0]        wadr_a;
    logic [19:0]       wd_a = '0;
    logic [4:0]        a_in0, a_in1, a_in2, a_in3, a_w0, a_w1, a_w2, a_w3;
    logic [19:0]       wmem_a [2];

    // DUT B: NUM_IN=6 (padded last beat)
    logic              vb = 1'b0;
    logic [4:0]        db = '0;
    logic              rb, ir_b, gl_b;
    logic [0:0]        wadr_b;
    logic [19:0]       wd_b = '0;
    logic [4:0]        b_in0, b_in1, b_in2, b_in3, b_w0, b_w1, b_w2, b_w3;
    logic [19:0]       wmem_b [2];

    // DUT C: NUM_IN=1
    logic              vc = 1'b0;
    logic [4:0]        dc = '0;
    logic              rc, ir_c, gl_c;
    logic [0:0]        wadr_c;
    logic [19:0]       wd_c = '0;
    logic [4:0]        c_in0, c_in1, c_in2, c_in3, c_w0, c_w1, c_w2, c_w3;
    logic [19:0]       wmem_c [2];

    neuron_feeder #(.IN_W(5), .NUM_IN(NA)) dut_a (
        .gated_clk(clk), .rst_n(rst_n), .act_valid(va), .act_ready(ra), .act_data(da),
        .wt_addr(wadr_a), .wt_data(wd_a),
        .in0(a_in0), .in1(a_in1), .in2(a_in2), .in3(a_in3),
        .w0(a_w0), .w1(a_w1), .w2(a_w2), .w3(a_w3),
        .input_ready(ir_a), .group_last(gl_a)
    );

    neuron_feeder #(.IN_W(5), .NUM_IN(6)) dut_b (
        .gated_clk(clk), .rst_n(rst_n), .act_valid(vb), .act_ready(rb), .act_data(db),
        .wt_addr(wadr_b), .wt_data(wd_b),
        .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3),
        .w0(b_w0), .w1(b_w1), .w2(b_w2), .w3(b_w3),
        .input_ready(ir_b), .group_last(gl_b)
    );

    neuron_feeder #(.IN_W(5), .NUM_IN(1)) dut_c (
        .gated_clk(clk), .rst_n(rst_n), .act_valid(vc), .act_ready(rc), .act_data(dc),
        .wt_addr(wadr_c), .wt_data(wd_c),
        .in0(c_in0), .in1(c_in1), .in2(c_in2), .in3(c_in3),
        .w0(c_w0), .w1(c_w1), .w2(c_w2), .w3(c_w3),
        .input_ready(ir_c), .group_last(gl_c)
    );

    // Synchronous weight memories: data valid one cycle after the address.
    always @(posedge clk) begin
        wd_a <= wmem_a[wadr_a];
        wd_b <= wmem_b[wadr_b];
        wd_c <= wmem_c[wadr_c];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int beat_sum(input beat_t b);
        int s = 0;
        for (int k = 0; k < 4; k++)
            s += int'($signed(b.ins[5*k +: 5])) * int'($signed(b.ws[5*k +: 5]));
        return s;
    endfunction

    // Reference model for DUT A: a vector completes after NA accepts; its
    // NGA beats then appear 3..2+NGA cycles later and readiness drops for NGA+1 cycles.
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [4:0]  m_vec [NA];
    int          m_cnt = 0;
    int          m_busy = 0;
    logic [19:0] last_ins = '0;
    logic [19:0] last_ws = '0;

    always @(negedge clk) begin
        logic [19:0] o_ins, o_ws;
        beat_t b;
        cyc++;
        o_ins = {a_in3, a_in2, a_in1, a_in0};
        o_ws  = {a_w3, a_w2, a_w1, a_w0};
        if (ir_a) begin
            b.cyc = cyc; b.ins = o_ins; b.ws = o_ws; b.last = gl_a;
            obs_q.push_back(b);
        end
        if (!rst_n) begin
            check("reset act_ready", 32'(ra), 32'd1);
            check("reset input_ready", 32'(ir_a), 32'd0);
            check("reset group_last", 32'(gl_a), 32'd0);
            check("reset in lanes", 32'(o_ins), 32'd0);
            check("reset w lanes", 32'(o_ws), 32'd0);
            exp_q.delete();
            m_cnt = 0; m_busy = 0; last_ins = '0; last_ws = '0;
        end else begin
            check("act_ready", 32'(ra), 32'(m_busy == 0));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                b = exp_q.pop_front();
                last_ins = b.ins;
                last_ws  = b.ws;
                check("beat input_ready", 32'(ir_a), 32'd1);
                check("beat group_last", 32'(gl_a), 32'(b.last));
            end else begin
                check("idle input_ready", 32'(ir_a), 32'd0);
                check("idle group_last", 32'(gl_a), 32'd0);
            end
            check("in lanes", 32'(o_ins), 32'(last_ins));
            check("w lanes", 32'(o_ws), 32'(last_ws));
            if (m_busy > 0) begin
                m_busy--;
            end else if (va) begin
                m_vec[m_cnt] = da;
                m_cnt++;
                if (m_cnt == NA) begin
                    m_cnt  = 0;
                    m_busy = NGA + 1;
                    for (int g = 0; g < NGA; g++) begin
                        b.cyc  = cyc + 3 + g;
                        b.last = (g == NGA - 1);
                        b.ws   = wmem_a[g];
                        for (int k = 0; k < 4; k++)
                            b.ins[5*k +: 5] = (4*g + k < NA) ? m_vec[4*g + k] : 5'd0;
                        exp_q.push_back(b);
                    end
                end
            end
        end
    end

    task automatic drive_a(input logic v, input logic [4:0] d);
        @(posedge clk); #1;
        va = v;
        da = d;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        beat_t       bq[$];
        beat_t       b;
        int          t_last;
        int          k;
        logic [4:0]  acts_b [6];

        wmem_a[0] = {4{5'd1}};
        wmem_a[1] = {4{5'd2}};
        wmem_b[0] = {4{5'b10000}};
        wmem_b[1] = {4{5'b10000}};
        wmem_c[0] = {5'd11, 5'd10, 5'd9, 5'd3};
        wmem_c[1] = {5'd13, 5'd13, 5'd13, 5'd13};
        acts_b = '{5'b10000, 5'd15, 5'b11111, 5'd7, 5'd3, 5'b11110};

        idle(2);
        check("por act_ready A", 32'(ra), 32'd1);
        check("por wt_addr A", 32'(wadr_a), 32'd0);
        check("por in0 A", 32'(a_in0), 32'd0);
        check("por act_ready C", 32'(rc), 32'd1);
        rst_n = 1'b1;

        // Acts 1..8 with group weights 1 and 2.
        idle(2);
        obs_q.delete();
        for (int i = 0; i < NA; i++) drive_a(1'b1, 5'(i + 1));
        drive_a(1'b0, 5'd0);
        idle(10);
        check("plan beat count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("plan beat0 in", 32'(obs_q[0].ins), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
            check("plan beat0 w", 32'(obs_q[0].ws), 32'({4{5'd1}}));
            check("plan beat0 last", 32'(obs_q[0].last), 32'd0);
            check("plan beat1 in", 32'(obs_q[1].ins), 32'({5'd8, 5'd7, 5'd6, 5'd5}));
            check("plan beat1 last", 32'(obs_q[1].last), 32'd1);
            check("plan sum0", 32'(beat_sum(obs_q[0])), 32'd10);
            check("plan sum1", 32'(beat_sum(obs_q[1])), 32'd52);
            check("plan beats contiguous", 32'(obs_q[1].cyc - obs_q[0].cyc), 32'd1);
        end

        // Toggled valid during LOAD, then valid held through PRIME/STREAM.
        obs_q.delete();
        for (int i = 0; i < 15; i++) drive_a(1'((i % 2) == 0), 5'(i / 2 + 9));
        t_last = cyc + 1;
        repeat (3) drive_a(1'b1, 5'd31);
        drive_a(1'b0, 5'd0);
        idle(8);
        check("toggle beat count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("toggle latency", 32'(obs_q[0].cyc - t_last), 32'd3);
            check("toggle beat0 in", 32'(obs_q[0].ins), 32'({5'd12, 5'd11, 5'd10, 5'd9}));
            check("toggle beat1 in", 32'(obs_q[1].ins), 32'({5'd16, 5'd15, 5'd14, 5'd13}));
        end

        // Back-to-back: two full vectors with valid held high.
        obs_q.delete();
        repeat (22) drive_a(1'b1, 5'($urandom));
        drive_a(1'b0, 5'd0);
        idle(10);
        check("b2b beat count", 32'(obs_q.size()), 32'd4);
        if (obs_q.size() >= 4) begin
            check("b2b vector period", 32'(obs_q[2].cyc - obs_q[0].cyc), 32'(NA + NGA + 1));
            check("b2b last flag A", 32'(obs_q[1].last), 32'd1);
            check("b2b last flag B", 32'(obs_q[3].last), 32'd1);
        end

        // Reset while streaming.
        obs_q.delete();
        repeat (NA) drive_a(1'b1, 5'($urandom));
        drive_a(1'b0, 5'd0);
        k = 0;
        while (obs_q.size() == 0 && k < 12) begin
            idle(1);
            k++;
        end
        check("beat before reset", 32'(obs_q.size() > 0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async input_ready", 32'(ir_a), 32'd0);
        check("async in lanes", 32'({a_in3, a_in2, a_in1, a_in0}), 32'd0);
        check("async w lanes", 32'({a_w3, a_w2, a_w1, a_w0}), 32'd0);
        check("async act_ready", 32'(ra), 32'd1);
        wmem_a[0] = 20'($urandom);
        wmem_a[1] = 20'($urandom);
        idle(2);
        rst_n = 1'b1;
        obs_q.delete();
        #1;
        check("post reset act_ready", 32'(ra), 32'd1);
        repeat (NA) drive_a(1'b1, 5'($urandom));
        drive_a(1'b0, 5'd0);
        idle(10);
        check("post reset beat count", 32'(obs_q.size()), 32'd2);

        // Randomized traffic against the model.
        repeat (400) drive_a(1'(($urandom % 3) != 0), 5'($urandom));
        drive_a(1'b0, 5'd0);
        idle(10);
        check("model drained", 32'(exp_q.size()), 32'd0);

        // NUM_IN=6: padded second beat, weights all -16.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            vb = 1'b1;
            db = acts_b[i];
        end
        @(posedge clk); #1;
        vb = 1'b0;
        bq.delete();
        repeat (10) begin
            @(negedge clk);
            if (ir_b) begin
                b.cyc = cyc; b.last = gl_b;
                b.ins = {b_in3, b_in2, b_in1, b_in0};
                b.ws  = {b_w3, b_w2, b_w1, b_w0};
                bq.push_back(b);
            end
        end
        check("pad beat count", 32'(bq.size()), 32'd2);
        if (bq.size() >= 2) begin
            check("pad beat0 in", 32'(bq[0].ins), 32'({5'd7, 5'b11111, 5'd15, 5'b10000}));
            check("pad beat0 last", 32'(bq[0].last), 32'd0);
            check("pad beat1 in", 32'(bq[1].ins), 32'({5'd0, 5'd0, 5'b11110, 5'd3}));
            check("pad beat1 w", 32'(bq[1].ws), 32'({4{5'b10000}}));
            check("pad beat1 last", 32'(bq[1].last), 32'd1);
            check("pad beat1 sum", 32'(beat_sum(bq[1])), 32'(-16));
        end

        // NUM_IN=1: single beat carrying group_last.
        @(posedge clk); #1;
        vc = 1'b1;
        dc = 5'b11011;
        @(posedge clk); #1;
        vc = 1'b0;
        bq.delete();
        repeat (8) begin
            @(negedge clk);
            if (ir_c) begin
                b.cyc = cyc; b.last = gl_c;
                b.ins = {c_in3, c_in2, c_in1, c_in0};
                b.ws  = {c_w3, c_w2, c_w1, c_w0};
                bq.push_back(b);
            end
        end
        check("single beat count", 32'(bq.size()), 32'd1);
        if (bq.size() >= 1) begin
            check("single beat in", 32'(bq[0].ins), 32'({5'd0, 5'd0, 5'd0, 5'b11011}));
            check("single beat w0", 32'(bq[0].ws[4:0]), 32'd3);
            check("single beat last", 32'(bq[0].last), 32'd1);
        end
        check("single act_ready back", 32'(rc), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
